// File: rtl/lock_sequencer.sv
// Boat-lock chamber controller: sequences gates and valves around an external countdown timer.
// Defining LOCK_TIMER_WDOG_EN adds a timer watchdog that latches a FAULT state until reset.
module lock_sequencer #(
  parameter int unsigned ENTRY_SECS = 300,
  parameter int unsigned FILL_SECS  = 420,
  parameter int unsigned DRAIN_SECS = 480,
  parameter int unsigned TW         = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_up,
  input  logic          req_down,
  input  logic          timer_done,
  output logic          timer_start,
  output logic [TW-1:0] timer_seconds,
  output logic          low_gate,
  output logic          high_gate,
  output logic          fill_valve,
  output logic          drain_valve,
  output logic          level_high,
  output logic          busy,
  output logic          fault
);

  typedef enum logic [3:0] {
    S_IDLE_LOW, S_IDLE_HIGH, S_ENTER_LOW, S_FILL, S_EXIT_HIGH,
    S_ENTER_HIGH, S_DRAIN, S_EXIT_LOW, S_REPOS_UP, S_REPOS_DOWN, S_FAULT
  } state_e;

  state_e        state_q, state_d;
  logic          pend_up_q, pend_up_d;
  logic          pend_dn_q, pend_dn_d;
  logic          armed_q, armed_d;
  logic          start_q, start_d;
  logic [TW-1:0] secs_q, secs_d;
  logic          low_gate_q, high_gate_q, fill_valve_q, drain_valve_q;
  logic          level_high_q, busy_q;
`ifdef LOCK_TIMER_WDOG_EN
  logic [2:0]    wd_q, wd_d;
  logic          fault_q;
`endif

  function automatic state_e next_after(input state_e s);
    case (s)
      S_ENTER_LOW:  return S_FILL;
      S_FILL:       return S_EXIT_HIGH;
      S_EXIT_HIGH:  return S_IDLE_HIGH;
      S_ENTER_HIGH: return S_DRAIN;
      S_DRAIN:      return S_EXIT_LOW;
      S_REPOS_UP:   return S_IDLE_HIGH;
      default:      return S_IDLE_LOW;
    endcase
  endfunction

  function automatic logic [TW-1:0] dur_of(input state_e s);
    case (s)
      S_ENTER_LOW, S_EXIT_HIGH, S_ENTER_HIGH, S_EXIT_LOW: return TW'(ENTRY_SECS);
      S_FILL, S_REPOS_UP:                                 return TW'(FILL_SECS);
      S_DRAIN, S_REPOS_DOWN:                              return TW'(DRAIN_SECS);
      default:                                            return '0;
    endcase
  endfunction

  function automatic logic is_timed(input state_e s);
    return (s != S_IDLE_LOW) && (s != S_IDLE_HIGH) && (s != S_FAULT);
  endfunction

  // Next state, request latching and timer handshake
  always_comb begin
    state_d   = state_q;
    pend_up_d = pend_up_q | req_up;
    pend_dn_d = pend_dn_q | req_down;
    armed_d   = armed_q;
    start_d   = 1'b0;
    secs_d    = secs_q;
`ifdef LOCK_TIMER_WDOG_EN
    wd_d      = wd_q;
`endif
    case (state_q)
      S_IDLE_LOW: begin
        if (pend_up_q) begin
          state_d   = S_ENTER_LOW;
          pend_up_d = 1'b0;
        end else if (pend_dn_q) begin
          state_d = S_REPOS_UP;
        end
      end
      S_IDLE_HIGH: begin
        if (pend_dn_q) begin
          state_d   = S_ENTER_HIGH;
          pend_dn_d = 1'b0;
        end else if (pend_up_q) begin
          state_d = S_REPOS_DOWN;
        end
      end
`ifdef LOCK_TIMER_WDOG_EN
      S_FAULT: state_d = S_FAULT;
`endif
      default: begin
        // A done level seen before the timer drops to 0 is stale and ignored
        if (armed_q && timer_done) begin
          state_d = next_after(state_q);
        end
`ifdef LOCK_TIMER_WDOG_EN
        else if (!armed_q && (wd_q == 3'd7)) begin
          state_d = S_FAULT;
        end
`endif
        else begin
          if (!timer_done) armed_d = 1'b1;
`ifdef LOCK_TIMER_WDOG_EN
          if (!start_q) wd_d = wd_q + 3'd1;
`endif
        end
      end
    endcase
    if ((state_d != state_q) && is_timed(state_d)) begin
      start_d = 1'b1;
      secs_d  = dur_of(state_d);
      armed_d = 1'b0;
`ifdef LOCK_TIMER_WDOG_EN
      wd_d    = 3'd0;
`endif
    end
  end

  // State and Moore outputs, registered from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE_LOW;
      pend_up_q     <= 1'b0;
      pend_dn_q     <= 1'b0;
      armed_q       <= 1'b0;
      start_q       <= 1'b0;
      secs_q        <= '0;
      low_gate_q    <= 1'b0;
      high_gate_q   <= 1'b0;
      fill_valve_q  <= 1'b0;
      drain_valve_q <= 1'b0;
      level_high_q  <= 1'b0;
      busy_q        <= 1'b0;
`ifdef LOCK_TIMER_WDOG_EN
      wd_q          <= 3'd0;
      fault_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pend_up_q     <= pend_up_d;
      pend_dn_q     <= pend_dn_d;
      armed_q       <= armed_d;
      start_q       <= start_d;
      secs_q        <= secs_d;
      low_gate_q    <= (state_d == S_ENTER_LOW)  || (state_d == S_EXIT_LOW);
      high_gate_q   <= (state_d == S_ENTER_HIGH) || (state_d == S_EXIT_HIGH);
      fill_valve_q  <= (state_d == S_FILL)       || (state_d == S_REPOS_UP);
      drain_valve_q <= (state_d == S_DRAIN)      || (state_d == S_REPOS_DOWN);
      level_high_q  <= (state_d == S_EXIT_HIGH)  || (state_d == S_IDLE_HIGH) ||
                       (state_d == S_ENTER_HIGH);
      busy_q        <= (state_d != S_IDLE_LOW)   && (state_d != S_IDLE_HIGH);
`ifdef LOCK_TIMER_WDOG_EN
      wd_q          <= wd_d;
      fault_q       <= (state_d == S_FAULT);
`endif
    end
  end

  assign timer_start   = start_q;
  assign timer_seconds = secs_q;
  assign low_gate      = low_gate_q;
  assign high_gate     = high_gate_q;
  assign fill_valve    = fill_valve_q;
  assign drain_valve   = drain_valve_q;
  assign level_high    = level_high_q;
  assign busy          = busy_q;
`ifdef LOCK_TIMER_WDOG_EN
  assign fault         = fault_q;
`else
  assign fault         = 1'b0;
`endif

endmodule

// File: tb/tb_lock_sequencer.sv
// Self-checking bench for lock_sequencer: behavioural countdown timer plus a phase-level
// reference model (passages expanded into timed phases of secs+2+load-delay cycles).
module tb_lock_sequencer;

  localparam int unsigned TW  = 10;
  localparam int unsigned E_S = 2;
  localparam int unsigned F_S = 3;
  localparam int unsigned D_S = 4;
  localparam int unsigned OW  = TW + 8;

  logic          clk;
  logic          reset;
  logic          req_up, req_down, timer_done;
  logic          timer_start;
  logic [TW-1:0] timer_seconds;
  logic          low_gate, high_gate, fill_valve, drain_valve, level_high, busy, fault;

  int n_chk  = 0;
  int n_fail = 0;

  lock_sequencer #(
    .ENTRY_SECS(E_S), .FILL_SECS(F_S), .DRAIN_SECS(D_S), .TW(TW)
  ) dut (
    .clk(clk), .reset(reset), .req_up(req_up), .req_down(req_down),
    .timer_done(timer_done), .timer_start(timer_start), .timer_seconds(timer_seconds),
    .low_gate(low_gate), .high_gate(high_gate), .fill_valve(fill_valve),
    .drain_valve(drain_valve), .level_high(level_high), .busy(busy), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Countdown timer; tdelay models a timer that loads late, holding a stale done meanwhile
  int            tdelay;
  logic          stuck_done;
  logic [TW-1:0] t_cnt, t_hold;
  int            t_dly;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      t_cnt  <= '0;
      t_hold <= '0;
      t_dly  <= 0;
    end else begin
      if (t_cnt != '0) t_cnt <= t_cnt - 1'b1;
      if (timer_start) begin
        if (tdelay == 0) t_cnt <= timer_seconds;
        else begin
          t_dly  <= tdelay;
          t_hold <= timer_seconds;
        end
      end else if (t_dly > 0) begin
        t_dly <= t_dly - 1;
        if (t_dly == 1) t_cnt <= t_hold;
      end
    end
  end
  assign timer_done = stuck_done | (t_cnt == '0);

  // Reference model: queue of timed phases for the passage being served
  typedef struct {
    logic          lg, hg, fv, dv, lh;
    logic [TW-1:0] secs;
    int            len;
  } phase_t;

  phase_t        m_q[$];
  int            m_el;
  logic          m_level, m_pu, m_pd;
  logic [TW-1:0] m_secs;

  function automatic phase_t ph(input logic lg, input logic hg, input logic fv,
                                input logic dv, input logic lh, input int unsigned s);
    phase_t p;
    p.lg = lg; p.hg = hg; p.fv = fv; p.dv = dv; p.lh = lh;
    p.secs = TW'(s);
    p.len  = int'(s) + 2 + tdelay;
    return p;
  endfunction

  always @(posedge clk or posedge reset) begin : model_b
    logic pu_n, pd_n;
    if (reset) begin
      m_q.delete();
      m_el    = 0;
      m_level = 1'b0;
      m_pu    = 1'b0;
      m_pd    = 1'b0;
      m_secs  = '0;
    end else begin
      pu_n = m_pu | req_up;
      pd_n = m_pd | req_down;
      if (m_q.size() != 0) begin
        m_el++;
        if (m_el == m_q[0].len) begin
          void'(m_q.pop_front());
          m_el = 0;
          if (m_q.size() == 0) m_level = ~m_level;
        end
      end else if (!m_level) begin
        if (m_pu) begin
          m_q.push_back(ph(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_S));
          m_q.push_back(ph(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, F_S));
          m_q.push_back(ph(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, E_S));
          pu_n = 1'b0;
        end else if (m_pd) begin
          m_q.push_back(ph(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, F_S));
        end
      end else begin
        if (m_pd) begin
          m_q.push_back(ph(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, E_S));
          m_q.push_back(ph(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, D_S));
          m_q.push_back(ph(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_S));
          pd_n = 1'b0;
        end else if (m_pu) begin
          m_q.push_back(ph(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, D_S));
        end
      end
      m_pu = pu_n;
      m_pd = pd_n;
      if (m_q.size() != 0 && m_el == 0) m_secs = m_q[0].secs;
    end
  end

  function automatic logic [OW-1:0] exp_vec();
    if (m_q.size() != 0)
      return {(m_el == 0), m_secs, m_q[0].lg, m_q[0].hg, m_q[0].fv, m_q[0].dv,
              m_q[0].lh, 1'b1, 1'b0};
    return {1'b0, m_secs, 4'b0000, m_level, 1'b0, 1'b0};
  endfunction

  function automatic logic [OW-1:0] obs_vec();
    return {timer_start, timer_seconds, low_gate, high_gate, fill_valve, drain_valve,
            level_high, busy, fault};
  endfunction

  function automatic logic model_idle();
    return (m_q.size() == 0) && !m_pu && !m_pd;
  endfunction

  task automatic apply_reset(input int dly);
    @(negedge clk);
    reset = 1'b1; req_up = 1'b0; req_down = 1'b0; stuck_done = 1'b0; tdelay = dly;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    n_chk++;
    if (obs_vec() !== '0) begin
      n_fail++; $display("FAIL reset_async got=%h exp=0", obs_vec());
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_chk++;
      if (obs_vec() !== '0) begin
        n_fail++; $display("FAIL reset_idle c=%0d got=%h exp=0", c, obs_vec());
      end
    end
  endtask

  task automatic test_up_passage();
    int got[$];
    int exp_s[$] = '{2, 3, 2};
    bit ok = 0;
    apply_reset(0);
    req_up = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      n_chk++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL up_trace c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      if (timer_start === 1'b1) got.push_back(int'(timer_seconds));
      req_up = 1'b0;
      if (model_idle()) begin ok = 1; break; end
    end
    n_chk++;
    if (!ok || got != exp_s) begin
      n_fail++; $display("FAIL up_starts got=%p exp=%p done=%0d", got, exp_s, ok);
    end
    n_chk++;
    if (level_high !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL up_end level_high=%b busy=%b exp 1/0", level_high, busy);
    end
  endtask

  task automatic test_down_from_low();
    int got[$];
    int exp_s[$] = '{3, 2, 4, 2};
    bit ok = 0;
    apply_reset(0);
    req_down = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      n_chk++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL down_trace c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      if (timer_start === 1'b1) got.push_back(int'(timer_seconds));
      req_down = 1'b0;
      if (model_idle()) begin ok = 1; break; end
    end
    n_chk++;
    if (!ok || got != exp_s) begin
      n_fail++; $display("FAIL down_starts got=%p exp=%p done=%0d", got, exp_s, ok);
    end
    n_chk++;
    if (level_high !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL down_end level_high=%b busy=%b exp 0/0", level_high, busy);
    end
  endtask

  task automatic test_both_requests();
    int got[$];
    int exp_s[$] = '{2, 3, 2, 2, 4, 2};
    bit ok = 0;
    apply_reset(0);
    req_up = 1'b1; req_down = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      n_chk++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL both_trace c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      if (timer_start === 1'b1) got.push_back(int'(timer_seconds));
      req_up = 1'b0; req_down = 1'b0;
      if (model_idle()) begin ok = 1; break; end
    end
    n_chk++;
    if (!ok || got != exp_s) begin
      n_fail++; $display("FAIL both_starts got=%p exp=%p done=%0d", got, exp_s, ok);
    end
    n_chk++;
    if (level_high !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL both_end level_high=%b busy=%b exp 0/0", level_high, busy);
    end
  endtask

  task automatic test_stale_done();
    int  low_cyc = 0;
    bit  in_entry = 1;
    bit  ok = 0;
    apply_reset(3);
    req_up = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      n_chk++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL stale_trace c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      if (fill_valve === 1'b1) in_entry = 0;
      if (in_entry && low_gate === 1'b1) low_cyc++;
      req_up = 1'b0;
      if (model_idle()) begin ok = 1; break; end
    end
    n_chk++;
    if (!ok || low_cyc != int'(E_S) + 5) begin
      n_fail++; $display("FAIL stale_entry_len got=%0d exp=%0d done=%0d", low_cyc, E_S + 5, ok);
    end
  endtask

  task automatic test_reset_mid_fill();
    bit seen = 0;
    apply_reset(0);
    req_up = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      n_chk++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL rstfill_trace c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      req_up = 1'b0;
      if (fill_valve === 1'b1) begin seen = 1; break; end
    end
    req_down = 1'b1;
    @(negedge clk);
    req_down = 1'b0;
    n_chk++;
    if (!seen || fill_valve !== 1'b1) begin
      n_fail++; $display("FAIL rstfill_in_fill fill_valve=%b seen=%0d exp 1", fill_valve, seen);
    end
    #2 reset = 1'b1;
    #1;
    n_chk++;
    if (obs_vec() !== '0) begin
      n_fail++; $display("FAIL rstfill_async got=%h exp=0", obs_vec());
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      n_chk++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL rstfill_after c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
    end
    n_chk++;
    if (busy !== 1'b0 || level_high !== 1'b0) begin
      n_fail++; $display("FAIL rstfill_pending busy=%b level_high=%b exp 0/0", busy, level_high);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 5; it++) begin
      bit ok = 0;
      apply_reset(int'($urandom_range(0, 2)));
      for (int c = 0; c < 150; c++) begin
        @(negedge clk);
        n_chk++;
        if (obs_vec() !== exp_vec()) begin
          n_fail++;
          $display("FAIL rand_trace it=%0d c=%0d got=%h exp=%h", it, c, obs_vec(), exp_vec());
        end
        req_up   = ($urandom_range(0, 11) == 0);
        req_down = ($urandom_range(0, 11) == 0);
      end
      req_up = 1'b0; req_down = 1'b0;
      for (int c = 0; c < 400; c++) begin
        @(negedge clk);
        n_chk++;
        if (obs_vec() !== exp_vec()) begin
          n_fail++;
          $display("FAIL rand_drain it=%0d c=%0d got=%h exp=%h", it, c, obs_vec(), exp_vec());
        end
        if (model_idle()) begin ok = 1; break; end
      end
      n_chk++;
      if (!ok || busy !== 1'b0) begin
        n_fail++; $display("FAIL rand_settle it=%0d busy=%b done=%0d exp idle", it, busy, ok);
      end
    end
  endtask

`ifdef LOCK_TIMER_WDOG_EN
  task automatic test_watchdog();
    bit seen = 0;
    apply_reset(0);
    stuck_done = 1'b1;
    req_up = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      req_up = 1'b0;
      if (timer_start === 1'b1) begin seen = 1; break; end
    end
    n_chk++;
    if (!seen) begin
      n_fail++; $display("FAIL wdog_start timer_start never seen exp 1");
    end
    for (int j = 1; j <= 9; j++) begin
      @(negedge clk);
      n_chk++;
      if (j < 9) begin
        if (fault !== 1'b0 || low_gate !== 1'b1) begin
          n_fail++; $display("FAIL wdog_early j=%0d fault=%b low_gate=%b exp 0/1", j, fault, low_gate);
        end
      end else if ({fault, busy, low_gate, high_gate, fill_valve, drain_valve} !== 6'b110000) begin
        n_fail++;
        $display("FAIL wdog_fault got=%b exp=110000",
                 {fault, busy, low_gate, high_gate, fill_valve, drain_valve});
      end
    end
    req_up = 1'b1;
    @(negedge clk);
    req_up = 1'b0;
    repeat (6) @(negedge clk);
    n_chk++;
    if ({fault, busy, low_gate, high_gate, fill_valve, drain_valve} !== 6'b110000) begin
      n_fail++;
      $display("FAIL wdog_sticky got=%b exp=110000",
               {fault, busy, low_gate, high_gate, fill_valve, drain_valve});
    end
    #2 reset = 1'b1;
    #1;
    n_chk++;
    if (fault !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL wdog_reset fault=%b busy=%b exp 0/0", fault, busy);
    end
    @(negedge clk);
    stuck_done = 1'b0;
    reset = 1'b0;
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; req_up = 1'b0; req_down = 1'b0; stuck_done = 1'b0; tdelay = 0;
    test_reset();
    test_up_passage();
    test_down_from_low();
    test_both_requests();
    test_stale_done();
    test_reset_mid_fill();
    test_random();
`ifdef LOCK_TIMER_WDOG_EN
    test_watchdog();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lock_sequencer.md
Name: lock_sequencer

Overview:
Chamber controller for the boat lock. It sits directly upstream of the countdown timer (counter): it issues the timer's start pulse and duration, and consumes the timer's done level to sequence the gates and valves. It moves the chamber between low and high water levels in response to latched up/down passage requests.

Parameters:
ENTRY_SECS, 300, duration of each gate-open phase (entry or exit), timer units.
FILL_SECS, 420, fill duration, low to high.
DRAIN_SECS, 480, drain duration, high to low.
TW, 10, timer duration width. All durations are nonzero and < 2^TW.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_up  in  1  pulse: boat at low side requests passage up
req_down  in  1  pulse: boat at high side requests passage down
timer_done  in  1  timer's done level (1 when timer count == 0)
timer_start  out  1  one-cycle start pulse to timer
timer_seconds  out  TW  duration presented to timer; stable for the whole timed state
low_gate  out  1  low-side gate open
high_gate  out  1  high-side gate open
fill_valve  out  1  filling
drain_valve  out  1  draining
level_high  out  1  chamber level is (or is settled) high
busy  out  1  any state other than IDLE_LOW / IDLE_HIGH
fault  out  1  watchdog fault (constant 0 without macro)

Behaviour:
- Reset (async, immediate): state IDLE_LOW; pending_up = pending_down = 0; armed = 0; all outputs 0; timer_seconds = 0. Reset mid-sequence abandons the sequence, closes all gates and valves at once, and drops pending requests.
- Requests: req_up / req_down set pending_up / pending_down on any edge where sampled high, in any state. A flag clears on the edge that leaves an IDLE state to serve it. Re-requests while pending are absorbed.
- States and transitions:
  - IDLE_LOW: if pending_up -> ENTER_LOW; else if pending_down -> REPOS_UP. If both are pending, pending_up wins.
  - IDLE_HIGH: if pending_down -> ENTER_HIGH; else if pending_up -> REPOS_DOWN. If both are pending, pending_down wins.
  - ENTER_LOW (low_gate, ENTRY_SECS) -> FILL (fill_valve, FILL_SECS) -> EXIT_HIGH (high_gate, ENTRY_SECS) -> IDLE_HIGH.
  - ENTER_HIGH (high_gate, ENTRY_SECS) -> DRAIN (drain_valve, DRAIN_SECS) -> EXIT_LOW (low_gate, ENTRY_SECS) -> IDLE_LOW.
  - REPOS_UP (fill_valve, FILL_SECS) -> IDLE_HIGH.
  - REPOS_DOWN (drain_valve, DRAIN_SECS) -> IDLE_LOW.
- Timer handshake, applied in every timed state:
  - The state-entry edge sets timer_start = 1 for exactly one cycle, loads timer_seconds, and clears armed.
  - armed sets on the first edge in the state where timer_done == 0.
  - The state exits on the edge where armed && timer_done. Because the timer's done level is high before it loads, a stale done is ignored.
  - Consecutive timed states each produce a fresh start pulse; there is no idle cycle between them.
- Outputs are registered Moore outputs, valid in the same cycle as the state.
  - Safety invariant: low_gate & high_gate never both 1; fill_valve & drain_valve never both 1; no valve is open while any gate is open.
  - level_high = 1 in EXIT_HIGH, IDLE_HIGH, ENTER_HIGH; 0 elsewhere.
- Latency: a request pulse at edge N sets pending; when idle, the state leaves IDLE at edge N+1 and timer_start is high during cycle N+1..N+2.
- timer_seconds holds its last value in IDLE states and is 0 after reset.

Optional Feature:
- Macro: LOCK_TIMER_WDOG_EN.
- With the macro: a 3-bit watchdog counts cycles since timer_start. If armed is still 0 after 8 cycles, the next edge enters FAULT. In FAULT: all gates and valves 0, fault = 1, busy = 1, requests are still latched. Only reset exits FAULT.
- Without the macro: no watchdog, no FAULT state, fault tied to 0.

Test Plan:
1. Bench setup: ENTRY_SECS=2, FILL_SECS=3, DRAIN_SECS=4, behavioural counter model. Reset, then req_up pulse -> ENTER_LOW (low_gate=1, timer_seconds=2, one start pulse) -> FILL (timer_seconds=3) -> EXIT_HIGH -> IDLE_HIGH, with level_high=1 and busy=0 at the end.
2. From IDLE_LOW: req_down pulse -> REPOS_UP (fill_valve=1, timer_seconds=3) -> IDLE_HIGH -> ENTER_HIGH (timer_seconds=2) -> DRAIN (timer_seconds=4) -> EXIT_LOW -> IDLE_LOW; each phase has exactly one start pulse.
3. req_up and req_down in the same cycle at IDLE_LOW -> up passage served first, then the down passage runs from IDLE_HIGH without a new request.
4. Hold timer_done=1 for 3 cycles after timer_start -> no premature exit; the state exits only after timer_done goes 0 then 1.
5. Assert reset during FILL -> same cycle: fill_valve=0, all outputs 0, state IDLE_LOW, pending flags cleared.
6. Macro defined, timer_done stuck at 1 -> FAULT after 9 cycles past timer_start, fault=1, all gates and valves 0; req_up has no effect until reset.
